// File: rtl/gcd_lcm_pkg.sv
// Shared state encoding and operation codes for the GCD/LCM unit.
// The DIV and MUL states only exist when GCD_LCM_UNIT_LCM_EN is defined.
package gcd_lcm_pkg;

   localparam logic OP_GCD = 1'b0;
   localparam logic OP_LCM = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      REDUCE,
`ifdef GCD_LCM_UNIT_LCM_EN
      DIV,
      MUL,
`endif
      DONE
   } state_e;

endpackage

// File: rtl/gcd_lcm_unit_if.sv
// Request/response bundle for gcd_lcm_unit; master drives requests, slave answers.
interface gcd_lcm_unit_if #(
   parameter int WIDTH = 32
) ();

   logic               start_i;
   logic               op_i;
   logic [WIDTH-1:0]   a_i;
   logic [WIDTH-1:0]   b_i;
   logic               busy_o;
   logic               done_o;
   logic [2*WIDTH-1:0] result_o;
   logic               err_o;

   modport master (
      output start_i, op_i, a_i, b_i,
      input  busy_o, done_o, result_o, err_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i,
      output busy_o, done_o, result_o, err_o
   );

endinterface

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD datapath: one reduction step per enabled cycle.
// fin_o flags x==y (both odd); g_o is then the GCD with the common power of two restored.
module gcd_stein_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             fin_o,
   output logic [WIDTH-1:0] g_o
);

   localparam int KW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [KW-1:0]    k_q, k_d;

   // Equal operands can only be odd here: equal and even takes the halving branch first.
   assign fin_o = (x_q == y_q) && x_q[0];
   assign g_o   = x_q << k_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      k_d = k_q;
      if (load_i) begin
         x_d = a_i;
         y_d = b_i;
         k_d = '0;
      end else if (en_i) begin
         if (!x_q[0] && !y_q[0]) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + KW'(1);
         end else if (!x_q[0]) begin
            x_d = x_q >> 1;
         end else if (!y_q[0]) begin
            y_d = y_q >> 1;
         end else if (x_q > y_q) begin
            x_d = x_q - y_q;
         end else if (y_q > x_q) begin
            y_d = y_q - x_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
         k_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         k_q <= k_d;
      end
   end

endmodule

// File: rtl/gcd_lcm_unit.sv
// Sequential GCD/LCM unit: Stein GCD, then LCM = (a/g)*b via restoring divide and shift-add multiply.
// LCM hardware is present only when GCD_LCM_UNIT_LCM_EN is defined; otherwise LCM requests flag err_o.
module gcd_lcm_unit
   import gcd_lcm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               err_o
);

   state_e             state_q, state_d;
   logic               op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               err_q, err_d;
   logic               core_load, core_en, core_fin;
   logic [WIDTH-1:0]   core_g;

`ifdef GCD_LCM_UNIT_LCM_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH:0]     rem_shift;
   logic [2*WIDTH-1:0] acc_sum;
`endif

   gcd_stein_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .load_i (core_load),
      .en_i   (core_en),
      .a_i    (a_i),
      .b_i    (b_i),
      .fin_o  (core_fin),
      .g_o    (core_g)
   );

   assign done_o   = (state_q == DONE);
   assign busy_o   = (state_q != IDLE) && (state_q != DONE);
   assign result_o = result_q;
   assign err_o    = err_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      err_d     = err_q;
      core_load = 1'b0;
      core_en   = 1'b0;
`ifdef GCD_LCM_UNIT_LCM_EN
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      acc_sum   = quo_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d      = op_i;
               a_d       = a_i;
               b_d       = b_i;
               core_load = 1'b1;
`ifdef GCD_LCM_UNIT_LCM_EN
               state_d   = (a_i == '0 || b_i == '0) ? ZERO : REDUCE;
`else
               // Unsupported LCM shares the one-cycle ZERO path so it answers with the same timing.
               state_d   = (op_i == OP_LCM || a_i == '0 || b_i == '0) ? ZERO : REDUCE;
`endif
            end
         end
         ZERO: begin
            state_d = DONE;
            err_d   = 1'b0;
            if (op_q == OP_LCM) begin
               result_d = '0;
`ifndef GCD_LCM_UNIT_LCM_EN
               err_d    = 1'b1;
`endif
            end else begin
               result_d = {{WIDTH{1'b0}}, (a_q == '0) ? b_q : a_q};
            end
         end
         REDUCE: begin
            core_en = 1'b1;
            if (core_fin) begin
`ifdef GCD_LCM_UNIT_LCM_EN
               if (op_q == OP_GCD) begin
                  state_d  = DONE;
                  result_d = {{WIDTH{1'b0}}, core_g};
                  err_d    = 1'b0;
               end else begin
                  state_d = DIV;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_q;
               end
`else
               state_d  = DONE;
               result_d = {{WIDTH{1'b0}}, core_g};
               err_d    = 1'b0;
`endif
            end
         end
`ifdef GCD_LCM_UNIT_LCM_EN
         DIV: begin
            // Remainder always stays below g, so WIDTH bits suffice.
            if (rem_shift >= {1'b0, core_g}) begin
               rem_d = WIDTH'(rem_shift - {1'b0, core_g});
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = MUL;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, b_q};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         MUL: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            quo_d   = quo_q >> 1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = DONE;
               result_d = acc_sum;
               err_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef GCD_LCM_UNIT_LCM_EN
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef GCD_LCM_UNIT_LCM_EN
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
`endif
      end
   end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Scoreboard bench for gcd_lcm_unit: an 8-bit and a 32-bit instance share one request driver.
// Expected results follow GCD_LCM_UNIT_LCM_EN (LCM computed, or err_o=1 with result 0).
module tb_gcd_lcm_unit;
   import gcd_lcm_pkg::*;

   logic        clk = 1'b0;
   logic        reset_r = 1'b1;
   logic        start_r = 1'b0;
   logic        op_r = 1'b0;
   logic        use32 = 1'b0;
   logic [31:0] a_r = '0;
   logic [31:0] b_r = '0;

   always #5 clk = ~clk;

   gcd_lcm_unit_if #(.WIDTH(8))  if8 ();
   gcd_lcm_unit_if #(.WIDTH(32)) if32 ();

   assign if8.start_i  = start_r & ~use32;
   assign if8.op_i     = op_r;
   assign if8.a_i      = a_r[7:0];
   assign if8.b_i      = b_r[7:0];
   assign if32.start_i = start_r & use32;
   assign if32.op_i    = op_r;
   assign if32.a_i     = a_r;
   assign if32.b_i     = b_r;

   gcd_lcm_unit #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .reset    (reset_r),
      .start_i  (if8.start_i),
      .op_i     (if8.op_i),
      .a_i      (if8.a_i),
      .b_i      (if8.b_i),
      .busy_o   (if8.busy_o),
      .done_o   (if8.done_o),
      .result_o (if8.result_o),
      .err_o    (if8.err_o)
   );

   gcd_lcm_unit #(.WIDTH(32)) u_dut32 (
      .clk      (clk),
      .reset    (reset_r),
      .start_i  (if32.start_i),
      .op_i     (if32.op_i),
      .a_i      (if32.a_i),
      .b_i      (if32.b_i),
      .busy_o   (if32.busy_o),
      .done_o   (if32.done_o),
      .result_o (if32.result_o),
      .err_o    (if32.err_o)
   );

   logic        done_s, busy_s, err_s;
   logic [63:0] res_s;

   always_comb begin
      if (use32) begin
         done_s = if32.done_o;
         busy_s = if32.busy_o;
         err_s  = if32.err_o;
         res_s  = if32.result_o;
      end else begin
         done_s = if8.done_o;
         busy_s = if8.busy_o;
         err_s  = if8.err_o;
         res_s  = {48'd0, if8.result_o};
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [63:0] res;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   function automatic logic [63:0] gcd_ref(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] t;
      while (b != 64'd0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Push expectation, issue one request, then wait (bounded) for done and score it.
   task automatic run_op(input string tag, input bit big, input bit op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, output int lat);
      exp_t        e;
      logic [63:0] am, bm, g;
      int          cyc;
      int          busy_lo;
      bit          seen;
      am = big ? {32'd0, a} : {56'd0, a[7:0]};
      bm = big ? {32'd0, b} : {56'd0, b[7:0]};
      g  = gcd_ref(am, bm);
      e.err = 1'b0;
      e.lat = -1;
      if (op == OP_GCD) begin
         e.res = g;
      end else begin
`ifdef GCD_LCM_UNIT_LCM_EN
         e.res = (am == 64'd0 || bm == 64'd0) ? 64'd0 : (am / g) * bm;
`else
         e.res = 64'd0;
         e.err = 1'b1;
         e.lat = 2;
`endif
      end
      if (am == 64'd0 || bm == 64'd0) e.lat = 2;
      sb_q.push_back(e);

      @(negedge clk);
      use32   = big;
      op_r    = op;
      a_r     = a;
      b_r     = b;
      start_r = 1'b1;
      cyc     = 0;
      busy_lo = 0;
      seen    = 1'b0;
      while (!seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start_r = (cyc == poke_at);
         if (cyc == poke_at) begin
            a_r = a ^ 32'h5;
            b_r = b + 32'd1;
         end
         if (done_s) seen = 1'b1;
         else if (!busy_s) busy_lo++;
      end
      start_r = 1'b0;
      lat = cyc;
      e = sb_q.pop_front();
      check_eq({tag, ":done_seen"}, seen, 1);
      if (seen) begin
         check_eq({tag, ":res"}, res_s, e.res);
         check_eq({tag, ":err"}, err_s, e.err);
         check_eq({tag, ":busy"}, busy_lo, 0);
         if (e.lat >= 0) check_eq({tag, ":lat"}, lat, e.lat);
         $display("txn %s w=%0d op=%0d a=0x%0h b=0x%0h res=0x%0h err=%0d lat=%0d",
                  tag, big ? 32 : 8, op, a, b, res_s, err_s, lat);
         @(negedge clk);
         check_eq({tag, ":done_pulse"}, done_s, 0);
         check_eq({tag, ":idle"}, busy_s, 0);
         check_eq({tag, ":held"}, res_s, e.res);
      end
   endtask

   int lat, lat_g, lat_l, done_bad;

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst8:done", if8.done_o, 0);
      check_eq("rst8:busy", if8.busy_o, 0);
      check_eq("rst8:res", if8.result_o, 0);
      check_eq("rst8:err", if8.err_o, 0);
      check_eq("rst32:done", if32.done_o, 0);
      check_eq("rst32:busy", if32.busy_o, 0);
      check_eq("rst32:res", if32.result_o, 0);
      check_eq("rst32:err", if32.err_o, 0);
      reset_r = 1'b0;

      run_op("gcd48_18", 1'b0, OP_GCD, 32'd48, 32'd18, -1, lat);
      run_op("gcd21_6", 1'b0, OP_GCD, 32'd21, 32'd6, -1, lat_g);
      run_op("lcm21_6", 1'b0, OP_LCM, 32'd21, 32'd6, -1, lat_l);
`ifdef GCD_LCM_UNIT_LCM_EN
      check_eq("lcm21_6:extra_lat", lat_l - lat_g, 16);
`endif
      run_op("gcd0_7", 1'b0, OP_GCD, 32'd0, 32'd7, -1, lat);
      run_op("lcm0_7", 1'b0, OP_LCM, 32'd0, 32'd7, -1, lat);
      run_op("gcd0_0", 1'b0, OP_GCD, 32'd0, 32'd0, -1, lat);
      run_op("gcd7_0", 1'b0, OP_GCD, 32'd7, 32'd0, -1, lat);
      run_op("lcm_big", 1'b1, OP_LCM, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, lat);
      run_op("poke", 1'b0, OP_GCD, 32'd200, 32'd3, 2, lat);
      run_op("lcm4_6", 1'b0, OP_LCM, 32'd4, 32'd6, -1, lat);

      // Abort a request mid-reduction; nothing may complete and outputs must clear.
      @(negedge clk);
      use32   = 1'b0;
      op_r    = OP_GCD;
      a_r     = 32'd200;
      b_r     = 32'd3;
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      @(negedge clk);
      check_eq("abort:busy_before", busy_s, 1);
      reset_r  = 1'b1;
      done_bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (done_s) done_bad++;
      end
      check_eq("abort:no_done", done_bad, 0);
      check_eq("abort:busy", busy_s, 0);
      check_eq("abort:res", res_s, 0);
      check_eq("abort:err", err_s, 0);
      @(posedge clk);
      #1 reset_r = 1'b0;
      run_op("gcd12_8", 1'b0, OP_GCD, 32'd12, 32'd8, -1, lat);
      run_op("gcd4_6", 1'b0, OP_GCD, 32'd4, 32'd6, -1, lat);

      for (int i = 0; i < 20; i++) begin
         run_op("rand8", 1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                32'($urandom_range(0, 255)), -1, lat);
      end
      for (int i = 0; i < 6; i++) begin
         run_op("rand32", 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, -1, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
